pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage of the bbtron-enhanced core.
- Owns the PC register and the handshake with instruction memory.
- Presents one fetched instruction at a time to decode.
- Selects the next PC from: sequential, taken branch, J-type target (the 32-bit output of the J-type sign extender), or register target (jr).

Parameters:
- ADDR_WIDTH, 32, PC/address width; all arithmetic is modulo 2^ADDR_WIDTH.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 1, sequential increment (memory is word-addressed).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- jumpTarget  input  32  absolute J-type target from the J-type sign extender.
- branchOffset  input  32  signed branch offset, already sign-extended.
- regTarget  input  32  register value for jr.
- pcSrc  input  2  next-PC selection: 00 seq, 01 branch, 10 jump, 11 jr.
- branchTaken  input  1  branch condition result; used only when pcSrc=01.
- stall  input  1  decode/execute not ready; hold the current instruction.
- halt  input  1  halt instruction decoded.
- imemReq  output  1  fetch request, held until acknowledged.
- imemAddr  output  32  fetch address, equal to pc.
- imemAck  input  1  memory returns data this cycle.
- imemData  input  32  instruction word, valid when imemAck=1.
- instrOut  output  32  registered instruction presented to decode.
- instrValid  output  1  instrOut valid; pcSrc/branchTaken/stall/halt are sampled only while this is 1.
- pc  output  32  address of instrOut / current fetch.
- pcPlusOne  output  32  pc+PC_STEP, used as the jal link value.

Behaviour:
- Clock and reset: one clock `clock`. Reset `reset` is synchronous and active-high, and has priority over every other input in every state.
- Reset values: pc=RESET_PC, state=BOOT, instrOut=0, instrValid=0, imemReq=0.
- State outputs: imemReq=(state==FETCH) and instrValid=(state==ISSUE), both decoded from the registered state (glitch-free). imemAddr=pc combinationally.
- BOOT: unconditionally go to FETCH next cycle. This guarantees a one-cycle gap after reset before the first request.
- FETCH:
  - imemReq=1; imemAddr stays stable until ack.
  - On imemAck=1 (a same-cycle ack is legal, i.e. zero-wait memory): instrOut<=imemData, go to ISSUE.
  - Otherwise remain in FETCH.
- ISSUE, evaluated in priority order:
  - stall=1: hold pc, instrOut and state, regardless of pcSrc and halt.
  - stall=0 and halt=1: go to HALTED; pc is unchanged.
  - Otherwise: pc<=nextPc, go to FETCH.
- HALTED: imemReq=0, instrValid=0, pc frozen. The only exit is reset.
- nextPc (all sums modulo 2^32, wrap-around silent):
  - 00 → pc+PC_STEP
  - 01 → branchTaken ? pc+PC_STEP+branchOffset : pc+PC_STEP
  - 10 → jumpTarget
  - 11 → regTarget
- branchTaken is ignored unless pcSrc=01.
- imemAck outside FETCH is ignored, and imemData is not captured.
- Throughput: minimum 2 cycles per instruction (FETCH with same-cycle ack, then ISSUE). Each memory wait cycle adds 1.
- Reset during FETCH abandons the outstanding request: imemReq=0 from the next cycle, and any late ack arrives in BOOT and is ignored.
- Redirect latency: the new imemAddr appears in the cycle immediately after the ISSUE cycle. There is no speculative fetch and nothing to flush.

Decomposition:
- Shared header (bbtron defines file): pcSrc encodings PC_SEQ/PC_BRANCH/PC_JUMP/PC_JR, and state encodings BOOT/FETCH/ISSUE/HALTED.
- One combinational sub-module, next_pc_calc: inputs pc, pcSrc, branchTaken, branchOffset, jumpTarget, regTarget; outputs nextPc and pcPlusOne.
- The FSM and registers stay in pc_fetch_unit.

Test Plan:
- Reset for 2 cycles, zero-wait memory acking every request, pcSrc=00 → imemReq rises 1 cycle after reset release with imemAddr=0. instrValid on the following cycle. Next imemAddr=1, instruction every 2 cycles.
- Ack delayed 3 cycles at pc=0x4 → imemReq high for 4 consecutive cycles with imemAddr=0x4 stable. instrOut=imemData captured exactly once. instrValid pulses 1 cycle.
- At pc=0x10, pcSrc=10, jumpTarget=0x00000200 → pcPlusOne=0x11 during ISSUE, next imemAddr=0x200. Same pc with pcSrc=11, regTarget=0xFFFFFFFF → fetch 0xFFFFFFFF, then sequential fetch at 0x00000000 (wrap).
- At pc=0x10, pcSrc=01, branchOffset=0xFFFFFFFC, branchTaken=1 → next imemAddr=0x0D. With branchTaken=0 → 0x11. With pcSrc=00 and branchTaken=1 → 0x11.
- stall=1 for 3 cycles in ISSUE with pcSrc=10 and halt=1 toggling → instrOut/pc/instrValid held and no imemReq. Release stall with halt=0 → jump taken.
- halt=1, stall=0 in ISSUE → HALTED, imemReq stays 0 for 20 cycles and ack pulses are ignored. Separately, assert reset mid-FETCH with a late ack → pc=RESET_PC, instrValid=0, the ack is not captured, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the bbtron fetch stage:
// next-PC source selection and fetch FSM states.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_JR     = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        BOOT   = 2'b00,
        FETCH  = 2'b01,
        ISSUE  = 2'b10,
        HALTED = 2'b11
    } state_e;

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Next-PC selection: sequential, branch, J-type target or jr.
// Purely combinational; all sums wrap modulo 2^ADDR_WIDTH.
module next_pc_calc
    import pc_fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int PC_STEP    = 1
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [1:0]            pcSrc,
    input  logic                  branchTaken,
    input  logic [ADDR_WIDTH-1:0] branchOffset,
    input  logic [ADDR_WIDTH-1:0] jumpTarget,
    input  logic [ADDR_WIDTH-1:0] regTarget,
    output logic [ADDR_WIDTH-1:0] nextPc,
    output logic [ADDR_WIDTH-1:0] pcPlusOne
);

    pc_src_e               w_src;
    logic [ADDR_WIDTH-1:0] w_seq;
    logic [ADDR_WIDTH-1:0] w_branch;

    assign w_src     = pc_src_e'(pcSrc);
    assign w_seq     = pc + ADDR_WIDTH'(PC_STEP);
    assign w_branch  = w_seq + branchOffset;
    assign pcPlusOne = w_seq;

    always_comb begin
        nextPc = w_seq;
        unique case (w_src)
            PC_SEQ:    nextPc = w_seq;
            PC_BRANCH: nextPc = branchTaken ? w_branch : w_seq;
            PC_JUMP:   nextPc = jumpTarget;
            PC_JR:     nextPc = regTarget;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch FSM of the bbtron core.
// One instruction in flight: FETCH until ack, then ISSUE to decode.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] jumpTarget,
    input  logic [ADDR_WIDTH-1:0] branchOffset,
    input  logic [ADDR_WIDTH-1:0] regTarget,
    input  logic [1:0]            pcSrc,
    input  logic                  branchTaken,
    input  logic                  stall,
    input  logic                  halt,
    output logic                  imemReq,
    output logic [ADDR_WIDTH-1:0] imemAddr,
    input  logic                  imemAck,
    input  logic [31:0]           imemData,
    output logic [31:0]           instrOut,
    output logic                  instrValid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pcPlusOne
);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [31:0]           r_instr;
    logic [ADDR_WIDTH-1:0] w_next_pc;
    logic                  w_capture;
    logic                  w_advance;

    next_pc_calc #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .PC_STEP   (PC_STEP)
    ) u_next_pc (
        .pc          (r_pc),
        .pcSrc       (pcSrc),
        .branchTaken (branchTaken),
        .branchOffset(branchOffset),
        .jumpTarget  (jumpTarget),
        .regTarget   (regTarget),
        .nextPc      (w_next_pc),
        .pcPlusOne   (pcPlusOne)
    );

    assign w_capture = (r_state == FETCH) && imemAck;
    assign w_advance = (r_state == ISSUE) && !stall && !halt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stall outranks halt; HALTED is left only through reset.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            BOOT:   w_state_nxt = FETCH;
            FETCH:  if (imemAck) w_state_nxt = ISSUE;
            ISSUE: begin
                if (!stall) begin
                    w_state_nxt = halt ? HALTED : FETCH;
                end
            end
            HALTED: w_state_nxt = HALTED;
        endcase
    end

    always_comb begin
        imemReq    = (r_state == FETCH);
        instrValid = (r_state == ISSUE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_instr <= '0;
        end else begin
            if (w_advance) r_pc <= w_next_pc;
            if (w_capture) r_instr <= imemData;
        end
    end

    assign imemAddr = r_pc;
    assign pc       = r_pc;
    assign instrOut = r_instr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: memory responder feeds a scoreboard
// of {addr, word}; each issued instruction is popped and compared.
module tb_pc_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] jumpTarget;
    logic [31:0] branchOffset;
    logic [31:0] regTarget;
    logic [1:0]  pcSrc;
    logic        branchTaken;
    logic        stall;
    logic        halt;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemData;
    logic [31:0] instrOut;
    logic        instrValid;
    logic [31:0] pc;
    logic [31:0] pcPlusOne;

    logic        mem_ack = 1'b0;
    logic [31:0] mem_data = '0;
    logic        tb_ack = 1'b0;
    logic [31:0] tb_data = '0;

    int          n_chk = 0;
    int          n_fail = 0;
    int          ack_delay = 0;
    int          wcnt = 0;
    logic [63:0] sb[$];
    bit          seen = 1'b0;

    always #5 clock = ~clock;

    assign imemAck  = mem_ack | tb_ack;
    assign imemData = mem_ack ? mem_data : tb_data;

    pc_fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .jumpTarget  (jumpTarget),
        .branchOffset(branchOffset),
        .regTarget   (regTarget),
        .pcSrc       (pcSrc),
        .branchTaken (branchTaken),
        .stall       (stall),
        .halt        (halt),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemAck     (imemAck),
        .imemData    (imemData),
        .instrOut    (instrOut),
        .instrValid  (instrValid),
        .pc          (pc),
        .pcPlusOne   (pcPlusOne)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'hA5A5_0000) + 32'h0000_1357;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory: acks after ack_delay wait cycles of a held request.
    always @(negedge clock) begin
        if (!imemReq) begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end else if (wcnt >= ack_delay) begin
            mem_ack  = 1'b1;
            mem_data = mem_word(imemAddr);
            sb.push_back({imemAddr, mem_word(imemAddr)});
            wcnt     = 0;
        end else begin
            mem_ack = 1'b0;
            wcnt++;
        end
    end

    always @(negedge clock) begin : mon
        logic [63:0] e;
        if (instrValid && !seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("iss_pc", pc, e[63:32]);
                chk("iss_instr", instrOut, e[31:0]);
            end
        end else if (!instrValid) begin
            seen = 1'b0;
        end
    end

    task automatic wait_issue(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!instrValid && n < 40);
        if (!instrValid) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Called at an ISSUE negedge: redirect, check fetch addr and arrival.
    task automatic go(input logic [1:0] src, input logic tk,
                      input logic [31:0] off, input logic [31:0] jt,
                      input logic [31:0] rt, input logic [31:0] exp,
                      input string tag);
        pcSrc        = src;
        branchTaken  = tk;
        branchOffset = off;
        jumpTarget   = jt;
        regTarget    = rt;
        @(negedge clock);
        pcSrc       = 2'b00;
        branchTaken = 1'b0;
        chk({tag, "_addr"}, imemAddr, exp);
        wait_issue(tag);
        chk({tag, "_pc"}, pc, exp);
    endtask

    initial begin
        int          n;
        logic [31:0] saved;
        reset        = 1'b1;
        pcSrc        = 2'b00;
        branchTaken  = 1'b0;
        branchOffset = '0;
        jumpTarget   = '0;
        regTarget    = '0;
        stall        = 1'b0;
        halt         = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_pc", pc, 32'd0);
        chk("rst_valid", 32'(instrValid), 32'd0);
        chk("rst_req", 32'(imemReq), 32'd0);
        chk("rst_instr", instrOut, 32'd0);
        reset = 1'b0;

        @(negedge clock);
        chk("boot_req", 32'(imemReq), 32'd1);
        chk("boot_addr", imemAddr, 32'd0);
        @(negedge clock);
        chk("first_valid", 32'(instrValid), 32'd1);
        chk("first_pcp1", pcPlusOne, 32'd1);
        @(negedge clock);
        chk("seq_req", 32'(imemReq), 32'd1);
        chk("seq_addr", imemAddr, 32'd1);
        @(negedge clock);
        chk("seq_valid", 32'(instrValid), 32'd1);

        ack_delay  = 3;
        pcSrc      = 2'b10;
        jumpTarget = 32'h4;
        n = 0;
        @(negedge clock);
        pcSrc = 2'b00;
        while (imemReq && n < 20) begin
            chk("dly_addr", imemAddr, 32'h4);
            n++;
            @(negedge clock);
        end
        chk("dly_len", 32'(n), 32'd4);
        chk("dly_valid", 32'(instrValid), 32'd1);
        ack_delay = 0;
        @(negedge clock);
        chk("dly_pulse", 32'(instrValid), 32'd0);
        wait_issue("seq5");
        chk("seq5_pc", pc, 32'h5);

        go(2'b10, 1'b1, 32'h0, 32'h10, 32'h0, 32'h10, "j10");
        chk("j10_pcp1", pcPlusOne, 32'h11);
        go(2'b10, 1'b0, 32'h0, 32'h200, 32'h0, 32'h200, "j200");
        go(2'b10, 1'b0, 32'h0, 32'h10, 32'h0, 32'h10, "j10b");
        go(2'b11, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, "jr");
        chk("jr_pcp1", pcPlusOne, 32'h0);
        go(2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, "wrap");

        go(2'b10, 1'b0, 32'h0, 32'h10, 32'h0, 32'h10, "j10c");
        go(2'b01, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0D, "br_t");
        go(2'b10, 1'b0, 32'h0, 32'h10, 32'h0, 32'h10, "j10d");
        go(2'b01, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h11, "br_nt");
        go(2'b10, 1'b0, 32'h0, 32'h10, 32'h0, 32'h10, "j10e");
        go(2'b00, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h11, "seq_tk");

        saved      = instrOut;
        stall      = 1'b1;
        pcSrc      = 2'b10;
        jumpTarget = 32'h300;
        for (int i = 0; i < 3; i++) begin
            halt = (i % 2 == 0);
            @(negedge clock);
            chk("st_valid", 32'(instrValid), 32'd1);
            chk("st_req", 32'(imemReq), 32'd0);
            chk("st_pc", pc, 32'h11);
            chk("st_instr", instrOut, saved);
        end
        stall = 1'b0;
        halt  = 1'b0;
        @(negedge clock);
        pcSrc = 2'b00;
        chk("st_addr", imemAddr, 32'h300);
        wait_issue("st");
        chk("st_pc2", pc, 32'h300);

        saved = instrOut;
        halt  = 1'b1;
        @(negedge clock);
        halt = 1'b0;
        chk("hl_enter", {30'd0, imemReq, instrValid}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            tb_ack  = i[0];
            tb_data = 32'hDEAD_BEEF;
            @(negedge clock);
            chk("hl_idle", {30'd0, imemReq, instrValid}, 32'd0);
            chk("hl_pc", pc, 32'h300);
            chk("hl_instr", instrOut, saved);
        end
        tb_ack = 1'b0;

        reset = 1'b1;
        @(negedge clock);
        reset     = 1'b0;
        ack_delay = 5;
        repeat (2) @(negedge clock);
        chk("rf_req", 32'(imemReq), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset   = 1'b0;
        tb_ack  = 1'b1;
        tb_data = 32'hBAD0_BAD0;
        chk("rf_req0", 32'(imemReq), 32'd0);
        chk("rf_pc", pc, 32'd0);
        chk("rf_valid", 32'(instrValid), 32'd0);
        @(negedge clock);
        tb_ack = 1'b0;
        chk("rf_nocap", instrOut, 32'd0);
        chk("rf_refetch", {31'd0, imemReq}, 32'd1);
        chk("rf_addr", imemAddr, 32'd0);
        wait_issue("rf");
        chk("rf_pc2", pc, 32'd0);
        ack_delay = 0;
        @(negedge clock);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
